// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
package dmem_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_CPU = 2'd1,
    GRANT_DMA = 2'd2,
    DONE      = 2'd3
  } state_e;

  // Owner of the transaction currently in flight
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of CPU grants made while the DMA port was waiting.
module dmem_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;

  assign at_max = (cnt_q == CW'(MAX));

  // Clear has priority; increment stops at MAX
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA master.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  output logic          cpu_stall_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic [DW-1:0] dma_rdata_o,
  output logic          dma_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i
);

  state_e state_q, state_d;
  owner_e owner_q;
  logic   grant_cpu_c, grant_dma_c, finish_c;
  logic   starve_clr_c, starve_inc_c, starve_at_max;

  dmem_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (starve_clr_c),
    .inc    (starve_inc_c),
    .at_max (starve_at_max)
  );

  // Pipeline stalls while its request is outstanding, released in the ack cycle
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

  // Next-state and arbitration decisions
  always_comb begin
    state_d      = state_q;
    grant_cpu_c  = 1'b0;
    grant_dma_c  = 1'b0;
    finish_c     = 1'b0;
    starve_clr_c = 1'b0;
    starve_inc_c = 1'b0;
    case (state_q)
      IDLE: begin
        starve_clr_c = ~dma_req_i;
        if (cpu_req_i && !(dma_req_i && starve_at_max)) begin
          grant_cpu_c  = 1'b1;
          starve_inc_c = dma_req_i;
          state_d      = GRANT_CPU;
        end else if (dma_req_i) begin
          grant_dma_c  = 1'b1;
          starve_clr_c = 1'b1;
          state_d      = GRANT_DMA;
        end
      end
      GRANT_CPU, GRANT_DMA: begin
        if (mem_ack_i) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched memory command, read data and ack pulses
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_rdata_o <= '0;
      dma_rdata_o <= '0;
      cpu_ack_o   <= 1'b0;
      dma_ack_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_ack_o <= 1'b0;
      dma_ack_o <= 1'b0;
      if (grant_cpu_c) begin
        owner_q     <= OWN_CPU;
        mem_req_o   <= 1'b1;
        mem_we_o    <= cpu_we_i;
        mem_addr_o  <= cpu_addr_i;
        mem_wdata_o <= cpu_wdata_i;
      end else if (grant_dma_c) begin
        owner_q     <= OWN_DMA;
        mem_req_o   <= 1'b1;
        mem_we_o    <= dma_we_i;
        mem_addr_o  <= dma_addr_i;
        mem_wdata_o <= dma_wdata_i;
      end
      if (finish_c) begin
        mem_req_o <= 1'b0;
        if (owner_q == OWN_CPU) begin
          cpu_ack_o <= 1'b1;
          if (!mem_we_o) cpu_rdata_o <= mem_rdata_i;
        end else begin
          dma_ack_o <= 1'b1;
          if (!mem_we_o) dma_rdata_o <= mem_rdata_i;
        end
      end
    end
  end

  // The granted requester must hold its request for the whole access
  cpu_req_held_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_q == GRANT_CPU) |-> cpu_req_i);
  dma_req_held_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_q == GRANT_DMA) |-> dma_req_i);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a random soak
// against a transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;

  localparam int unsigned AW          = 32;
  localparam int unsigned DW          = 32;
  localparam int unsigned STARVE_MAX  = 4;
  localparam int          SOAK_CYCLES = 10000;
  localparam int          PH_IDLE     = 0;
  localparam int          PH_BUSY     = 1;
  localparam int          PH_DONE     = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cpu_req_i, cpu_we_i, cpu_ack_o, cpu_stall_o;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i, cpu_rdata_o;
  logic          dma_req_i, dma_we_i, dma_ack_o;
  logic [AW-1:0] dma_addr_i;
  logic [DW-1:0] dma_wdata_i, dma_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  logic [DW-1:0] gmem [64];
  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
    .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_rdata_o(dma_rdata_o), .dma_ack_o(dma_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One-cycle-latency memory slave backed by gmem
  task automatic mem_respond();
    if (mem_req_o && !mem_ack_i) begin
      mem_ack_i = 1'b1;
      if (mem_we_o) begin
        gmem[mem_addr_o[7:2]] = mem_wdata_o;
        mem_rdata_i = $urandom;
      end else begin
        mem_rdata_i = gmem[mem_addr_o[7:2]];
      end
    end else begin
      mem_ack_i = 1'b0;
    end
  endtask

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic acked, output logic [31:0] rd);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 20 && !acked; i++) begin
      step();
      mem_respond();
      if (cpu_ack_o) begin
        acked = 1'b1;
        rd = cpu_rdata_o;
      end
    end
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dma_req_i = 1'b0; dma_we_i = 1'b0; dma_addr_i = '0; dma_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    #3;
    checks++;
    if ({mem_req_o, mem_we_o, cpu_ack_o, dma_ack_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_req_o, mem_we_o, cpu_ack_o, dma_ack_o});
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o, cpu_rdata_o, dma_rdata_o} !== 128'h0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", {mem_addr_o, mem_wdata_o, cpu_rdata_o, dma_rdata_o});
    end
    checks++;
    if (cpu_stall_o !== 1'b1) begin
      failures++; $display("FAIL reset_stall_hi: got %b expected 1", cpu_stall_o);
    end
    cpu_req_i = 1'b0;
    #1;
    checks++;
    if (cpu_stall_o !== 1'b0) begin
      failures++; $display("FAIL reset_stall_lo: got %b expected 0", cpu_stall_o);
    end
    step(); step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_cpu_read();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
    #1;
    checks++;
    if ({cpu_stall_o, mem_req_o} !== 2'b10) begin
      failures++; $display("FAIL t1_request: stall,mem_req got %b expected 10", {cpu_stall_o, mem_req_o});
    end
    step();
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, cpu_ack_o, cpu_stall_o} !== {2'b10, 32'h10, 2'b01}) begin
      failures++; $display("FAIL t1_grant: got %h expected %h", {mem_req_o, mem_we_o, mem_addr_o, cpu_ack_o, cpu_stall_o}, {2'b10, 32'h10, 2'b01});
    end
    step();
    checks++;
    if ({mem_req_o, cpu_ack_o, cpu_stall_o} !== 3'b101) begin
      failures++; $display("FAIL t1_wait: got %b expected 101", {mem_req_o, cpu_ack_o, cpu_stall_o});
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    step();
    checks++;
    if ({mem_req_o, cpu_ack_o, cpu_stall_o, cpu_rdata_o} !== {3'b010, 32'hDEADBEEF}) begin
      failures++; $display("FAIL t1_ack: got %h expected %h", {mem_req_o, cpu_ack_o, cpu_stall_o, cpu_rdata_o}, {3'b010, 32'hDEADBEEF});
    end
    cpu_req_i = 1'b0; mem_ack_i = 1'b0;
    step();
    checks++;
    if ({cpu_ack_o, dma_ack_o, mem_req_o} !== 3'b000) begin
      failures++; $display("FAIL t1_pulse_end: got %b expected 000", {cpu_ack_o, dma_ack_o, mem_req_o});
    end
  endtask

  task automatic test_starvation();
    int   ncpu;
    logic dma_seen, dma_acked, done;
    ncpu = 0; dma_seen = 1'b0; dma_acked = 1'b0; done = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h200;
    for (int i = 0; i < 80 && !done; i++) begin
      step();
      if (mem_req_o && !mem_ack_i) begin
        if (mem_addr_o == 32'h200) begin
          dma_seen = 1'b1;
          checks++;
          if (ncpu != int'(STARVE_MAX)) begin
            failures++; $display("FAIL t2_cpu_grants_before_dma: got %0d expected %0d", ncpu, STARVE_MAX);
          end
          checks++;
          if (int'(dut.u_starve.cnt_q) != 0) begin
            failures++; $display("FAIL t2_cnt_clear: got %0d expected 0", dut.u_starve.cnt_q);
          end
        end else if (!dma_seen) begin
          ncpu++;
          checks++;
          if (int'(dut.u_starve.cnt_q) != ncpu) begin
            failures++; $display("FAIL t2_cnt_inc: got %0d expected %0d", dut.u_starve.cnt_q, ncpu);
          end
        end
        mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      end else begin
        mem_ack_i = 1'b0;
      end
      if (dma_ack_o) begin
        dma_req_i = 1'b0; dma_acked = 1'b1;
      end
      if (cpu_ack_o && dma_acked) begin
        cpu_req_i = 1'b0; done = 1'b1;
      end
    end
    checks++;
    if ({dma_seen, done} !== 2'b11) begin
      failures++; $display("FAIL t2_complete: dma_granted,finished got %b expected 11", {dma_seen, done});
    end
    mem_ack_i = 1'b0;
    step(); step();
  endtask

  task automatic test_dma_then_cpu();
    int          first;
    logic        got_cpu;
    logic [31:0] rd;
    first = 0; got_cpu = 1'b0; rd = '0;
    gmem[16] = 32'h0;
    dma_req_i = 1'b1; dma_we_i = 1'b1; dma_addr_i = 32'h40; dma_wdata_i = 32'h12345678;
    step();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
    for (int i = 0; i < 30 && !got_cpu; i++) begin
      mem_respond();
      step();
      if (dma_ack_o) begin
        if (first == 0) first = 2;
        dma_req_i = 1'b0;
      end
      if (cpu_ack_o) begin
        if (first == 0) first = 1;
        got_cpu = 1'b1; rd = cpu_rdata_o; cpu_req_i = 1'b0;
      end
    end
    mem_ack_i = 1'b0;
    step();
    checks++;
    if (first != 2) begin
      failures++; $display("FAIL t3_order: first ack owner got %0d expected 2 (dma)", first);
    end
    checks++;
    if ({got_cpu, rd} !== {1'b1, 32'h12345678}) begin
      failures++; $display("FAIL t3_rdata: got %h expected %h", {got_cpu, rd}, {1'b1, 32'h12345678});
    end
  endtask

  task automatic test_reset_abort();
    dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h80;
    step();
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h80}) begin
      failures++; $display("FAIL t4_grant: got %h expected %h", {mem_req_o, mem_addr_o}, {1'b1, 32'h80});
    end
    step();
    #3;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, dma_ack_o} !== 2'b00) begin
      failures++; $display("FAIL t4_async_drop: got %b expected 00", {mem_req_o, dma_ack_o});
    end
    dma_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A;
    step();
    rst_i = 1'b1;
    step();
    checks++;
    if ({mem_req_o, dma_ack_o, cpu_ack_o, dma_rdata_o} !== 35'h0) begin
      failures++; $display("FAIL t4_late_ack: got %h expected 0", {mem_req_o, dma_ack_o, cpu_ack_o, dma_rdata_o});
    end
    mem_ack_i = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h8;
    step();
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h8}) begin
      failures++; $display("FAIL t4_idle_after: got %h expected %h", {mem_req_o, mem_addr_o}, {1'b1, 32'h8});
    end
    mem_respond();
    step();
    checks++;
    if (cpu_ack_o !== 1'b1) begin
      failures++; $display("FAIL t4_cpu_ack: got %b expected 1", cpu_ack_o);
    end
    cpu_req_i = 1'b0; mem_ack_i = 1'b0;
    step();
  endtask

  task automatic test_cpu_write();
    logic        acked;
    logic [31:0] rd;
    gmem[8] = 32'hAAAA5555;
    gmem[9] = 32'h0;
    cpu_access(1'b0, 32'h20, 32'h0, acked, rd);
    checks++;
    if ({acked, rd} !== {1'b1, 32'hAAAA5555}) begin
      failures++; $display("FAIL t5_setup_read: got %h expected %h", {acked, rd}, {1'b1, 32'hAAAA5555});
    end
    cpu_access(1'b1, 32'h24, 32'h11112222, acked, rd);
    checks++;
    if ({acked, rd} !== {1'b1, 32'hAAAA5555}) begin
      failures++; $display("FAIL t5_write_rdata: got %h expected %h", {acked, rd}, {1'b1, 32'hAAAA5555});
    end
    checks++;
    if (gmem[9] !== 32'h11112222) begin
      failures++; $display("FAIL t5_write_data: got %h expected 11112222", gmem[9]);
    end
    step();
    checks++;
    if ({cpu_ack_o, cpu_rdata_o} !== {1'b0, 32'hAAAA5555}) begin
      failures++; $display("FAIL t5_after: got %h expected %h", {cpu_ack_o, cpu_rdata_o}, {1'b0, 32'hAAAA5555});
    end
  endtask

  task automatic test_soak();
    int          phase, streak, lat, own, win, cpu_wait, dma_wait;
    int          cpu_iss, cpu_done, dma_iss, dma_done;
    logic        ack_sent, l_we, exp_cack, exp_dack, allow_new;
    logic [31:0] l_addr, l_wdata, exp_crd, exp_drd, ack_val;
    logic [64:0] exp_cmd;
    rst_i = 1'b0;
    cpu_req_i = 1'b0; dma_req_i = 1'b0; mem_ack_i = 1'b0;
    step();
    rst_i = 1'b1;
    phase = PH_IDLE; streak = 0; lat = 0; own = 0; win = 0; cpu_wait = 0; dma_wait = 0;
    cpu_iss = 0; cpu_done = 0; dma_iss = 0; dma_done = 0;
    ack_sent = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; exp_crd = '0; exp_drd = '0; ack_val = '0;
    for (int cyc = 0; cyc < SOAK_CYCLES + 400; cyc++) begin
      allow_new = (cyc < SOAK_CYCLES);
      if (!allow_new && !cpu_req_i && !dma_req_i && phase == PH_IDLE) break;
      step();
      exp_cack = 1'b0; exp_dack = 1'b0;
      case (phase)
        PH_IDLE: begin
          if (!dma_req_i) streak = 0;
          if (cpu_req_i && !(dma_req_i && streak == int'(STARVE_MAX))) win = 1;
          else if (dma_req_i) win = 2;
          else win = 0;
          if (win == 0) begin
            checks++;
            if (mem_req_o !== 1'b0) begin
              failures++; $display("FAIL soak_no_grant: cyc %0d mem_req got %b expected 0", cyc, mem_req_o);
            end
          end else begin
            exp_cmd = (win == 1) ? {cpu_we_i, cpu_addr_i, cpu_wdata_i} : {dma_we_i, dma_addr_i, dma_wdata_i};
            checks++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, exp_cmd}) begin
              failures++; $display("FAIL soak_grant: cyc %0d got %h expected %h (winner %0d)", cyc, {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, exp_cmd}, win);
            end
            if (win == 1 && dma_req_i && streak < int'(STARVE_MAX)) streak++;
            if (win == 2) streak = 0;
            own = win;
            {l_we, l_addr, l_wdata} = exp_cmd;
            lat = $urandom_range(0, 3);
            phase = PH_BUSY;
          end
        end
        PH_BUSY: begin
          if (ack_sent) begin
            checks++;
            if (mem_req_o !== 1'b0) begin
              failures++; $display("FAIL soak_req_drop: cyc %0d mem_req got %b expected 0", cyc, mem_req_o);
            end
            exp_cack = (own == 1);
            exp_dack = (own == 2);
            if (!l_we) begin
              if (own == 1) exp_crd = ack_val;
              else exp_drd = ack_val;
            end
            ack_sent = 1'b0;
            phase = PH_DONE;
          end else begin
            checks++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, l_we, l_addr, l_wdata}) begin
              failures++; $display("FAIL soak_stable: cyc %0d got %h expected %h", cyc, {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, l_we, l_addr, l_wdata});
            end
          end
        end
        default: begin
          checks++;
          if (mem_req_o !== 1'b0) begin
            failures++; $display("FAIL soak_done_req: cyc %0d mem_req got %b expected 0", cyc, mem_req_o);
          end
          phase = PH_IDLE;
        end
      endcase
      checks++;
      if ({cpu_ack_o, dma_ack_o} !== {exp_cack, exp_dack}) begin
        failures++; $display("FAIL soak_acks: cyc %0d got %b expected %b", cyc, {cpu_ack_o, dma_ack_o}, {exp_cack, exp_dack});
      end
      checks++;
      if ({cpu_rdata_o, dma_rdata_o} !== {exp_crd, exp_drd}) begin
        failures++; $display("FAIL soak_rdata: cyc %0d got %h expected %h", cyc, {cpu_rdata_o, dma_rdata_o}, {exp_crd, exp_drd});
      end
      checks++;
      if (cpu_stall_o !== (cpu_req_i & ~exp_cack)) begin
        failures++; $display("FAIL soak_stall: cyc %0d got %b expected %b", cyc, cpu_stall_o, cpu_req_i & ~exp_cack);
      end
      if (exp_cack) begin cpu_done++; cpu_req_i = 1'b0; end
      if (exp_dack) begin dma_done++; dma_req_i = 1'b0; end
      if (!cpu_req_i && allow_new && $urandom_range(0, 2) == 0) begin
        cpu_req_i = 1'b1; cpu_we_i = 1'($urandom_range(0, 1));
        cpu_addr_i = 32'($urandom_range(0, 15)) << 2; cpu_wdata_i = $urandom; cpu_iss++;
      end
      if (!dma_req_i && allow_new && $urandom_range(0, 2) == 0) begin
        dma_req_i = 1'b1; dma_we_i = 1'($urandom_range(0, 1));
        dma_addr_i = 32'($urandom_range(0, 15)) << 2; dma_wdata_i = $urandom; dma_iss++;
      end
      cpu_wait = cpu_req_i ? cpu_wait + 1 : 0;
      dma_wait = dma_req_i ? dma_wait + 1 : 0;
      if (cpu_wait > 100 || dma_wait > 100) begin
        checks++; failures++;
        $display("FAIL soak_timeout: cyc %0d cpu_wait %0d dma_wait %0d expected <= 100", cyc, cpu_wait, dma_wait);
        break;
      end
      if (phase == PH_BUSY) begin
        if (lat == 0) begin
          mem_ack_i = 1'b1;
          if (l_we) begin
            gmem[l_addr[7:2]] = l_wdata;
            mem_rdata_i = $urandom;
          end else begin
            mem_rdata_i = gmem[l_addr[7:2]];
          end
          ack_val = mem_rdata_i;
          ack_sent = 1'b1;
        end else begin
          lat--;
          mem_ack_i = 1'b0;
          mem_rdata_i = $urandom;
        end
      end else begin
        mem_ack_i = ($urandom_range(0, 7) == 0);
        mem_rdata_i = $urandom;
      end
      if (failures > 50) break;
    end
    mem_ack_i = 1'b0;
    checks++;
    if ({cpu_req_i, dma_req_i, cpu_iss == cpu_done, dma_iss == dma_done} !== 4'b0011) begin
      failures++; $display("FAIL soak_drain: cpu %0d/%0d dma %0d/%0d issued/acked, reqs %b", cpu_iss, cpu_done, dma_iss, dma_done, {cpu_req_i, dma_req_i});
    end
    checks++;
    if (cpu_done < 100 || dma_done < 100) begin
      failures++; $display("FAIL soak_activity: cpu acks %0d dma acks %0d expected >= 100 each", cpu_done, dma_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) gmem[i] = $urandom;
    test_reset();
    test_cpu_read();
    test_starvation();
    test_dma_then_cpu();
    test_reset_abort();
    test_cpu_write();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
